game_flow_controller: RTL

- Frame-timed sequencer for the gatorga game flow: start screen, level intro, play, respawn, level clear and game over.
- Owns the level counter, life counter and alien speed setting.
- Issues one-cycle wave-reset and respawn pulses to the alien/player datapaths.
- Drives per-screen select flags to the pixel mux in top. Timers are counted in frames using fsync.

---
 rtl/game_flow_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/game_flow_controller.sv
// Frame-timed game flow sequencer for gatorga: start screen, level intro, play,
// respawn delay, level clear and game over, plus the level/lives/speed bookkeeping.
module game_flow_controller #(
  parameter int LIVES_INIT      = 3,
  parameter int MAX_LEVEL       = 31,
  parameter int SPEED_BASE      = 1,
  parameter int SPEED_MAX       = 8,
  parameter int INTRO_FRAMES    = 120,
  parameter int RESPAWN_FRAMES  = 90,
  parameter int CLEAR_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 300
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       fsync,
  input  logic       start_btn,
  input  logic       aliens_cleared,
  input  logic       player_hit,
  output logic [2:0] state,
  output logic [4:0] level,
  output logic [2:0] lives,
  output logic [3:0] alien_speed,
  output logic       play_en,
  output logic       wave_reset,
  output logic       respawn,
  output logic       show_start,
  output logic       show_banner,
  output logic       game_over
);

  localparam logic [2:0] LIVES_LOAD    = 3'(LIVES_INIT);
  localparam logic [4:0] LEVEL_CAP     = 5'(MAX_LEVEL);
  localparam logic [3:0] SPEED_LOAD    = 4'(SPEED_BASE);
  localparam logic [3:0] SPEED_CAP     = 4'(SPEED_MAX);
  localparam logic [8:0] INTRO_LAST    = 9'(INTRO_FRAMES - 1);
  localparam logic [8:0] RESPAWN_LAST  = 9'(RESPAWN_FRAMES - 1);
  localparam logic [8:0] CLEAR_LAST    = 9'(CLEAR_FRAMES - 1);
  localparam logic [8:0] GAMEOVER_LAST = 9'(GAMEOVER_FRAMES - 1);

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_INTRO    = 3'd1,
    S_PLAY     = 3'd2,
    S_DOWN     = 3'd3,
    S_CLEAR    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [8:0] r_frameCnt;
  logic [8:0] w_nextFrameCnt;
  logic [8:0] w_timerLast;
  logic [4:0] r_level;
  logic [4:0] w_nextLevel;
  logic [2:0] r_lives;
  logic [2:0] w_nextLives;
  logic [3:0] r_speed;
  logic [3:0] w_nextSpeed;
  logic       r_btnPrev;
  logic       w_startRise;
  logic       w_timedState;
  logic       w_timerDone;
  logic       w_waveReset;
  logic       w_respawn;
  logic       r_playEn;
  logic       r_waveReset;
  logic       r_respawn;
  logic       r_showStart;
  logic       r_showBanner;
  logic       r_gameOver;

  assign w_startRise = start_btn & ~r_btnPrev;

  // Each timed screen expires on the fsync that finds the counter at its last frame.
  always_comb begin
    w_timerLast  = '0;
    w_timedState = 1'b1;
    case (r_state)
      S_INTRO:    w_timerLast = INTRO_LAST;
      S_DOWN:     w_timerLast = RESPAWN_LAST;
      S_CLEAR:    w_timerLast = CLEAR_LAST;
      S_GAMEOVER: w_timerLast = GAMEOVER_LAST;
      default:    w_timedState = 1'b0;
    endcase
    w_timerDone = w_timedState && fsync && (r_frameCnt == w_timerLast);
  end

  always_comb begin
    w_nextState = r_state;
    w_nextLevel = r_level;
    w_nextLives = r_lives;
    w_nextSpeed = r_speed;
    w_waveReset = 1'b0;
    w_respawn   = 1'b0;
    case (r_state)
      S_START: begin
        if (w_startRise) begin
          w_nextLevel = 5'd1;
          w_nextLives = LIVES_LOAD;
          w_nextSpeed = SPEED_LOAD;
          w_waveReset = 1'b1;
          w_nextState = S_INTRO;
        end
      end
      S_INTRO: begin
        if (w_timerDone) begin
          w_respawn   = 1'b1;
          w_nextState = S_PLAY;
        end
      end
      S_PLAY: begin
        // A hit outranks a simultaneous wave clear.
        if (player_hit) begin
          if (r_lives <= 3'd1) begin
            w_nextLives = 3'd0;
            w_nextState = S_GAMEOVER;
          end else begin
            w_nextLives = r_lives - 3'd1;
            w_nextState = S_DOWN;
          end
        end else if (aliens_cleared) begin
          w_nextState = S_CLEAR;
        end
      end
      S_DOWN: begin
        if (w_timerDone) begin
          w_respawn   = 1'b1;
          w_nextState = S_PLAY;
        end
      end
      S_CLEAR: begin
        if (w_timerDone) begin
          w_nextLevel = (r_level < LEVEL_CAP) ? r_level + 5'd1 : LEVEL_CAP;
          w_nextSpeed = (r_speed < SPEED_CAP) ? r_speed + 4'd1 : SPEED_CAP;
          w_waveReset = 1'b1;
          w_nextState = S_INTRO;
        end
      end
      S_GAMEOVER: begin
        if (w_timerDone) begin
          w_nextState = S_START;
        end
      end
      default: w_nextState = S_START;
    endcase

    if (w_nextState != r_state) begin
      w_nextFrameCnt = '0;
    end else if (w_timedState && fsync) begin
      w_nextFrameCnt = r_frameCnt + 9'd1;
    end else begin
      w_nextFrameCnt = r_frameCnt;
    end
  end

  // Screen flags and pulses are registered from the next state so they line up with it.
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_state      <= S_START;
      r_frameCnt   <= '0;
      r_level      <= '0;
      r_lives      <= '0;
      r_speed      <= SPEED_LOAD;
      r_btnPrev    <= 1'b1;
      r_playEn     <= 1'b0;
      r_waveReset  <= 1'b0;
      r_respawn    <= 1'b0;
      r_showStart  <= 1'b0;
      r_showBanner <= 1'b0;
      r_gameOver   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_frameCnt   <= w_nextFrameCnt;
      r_level      <= w_nextLevel;
      r_lives      <= w_nextLives;
      r_speed      <= w_nextSpeed;
      r_btnPrev    <= start_btn;
      r_playEn     <= (w_nextState == S_PLAY);
      r_waveReset  <= w_waveReset;
      r_respawn    <= w_respawn;
      r_showStart  <= (w_nextState == S_START);
      r_showBanner <= (w_nextState == S_INTRO);
      r_gameOver   <= (w_nextState == S_GAMEOVER);
    end
  end

  assign state       = r_state;
  assign level       = r_level;
  assign lives       = r_lives;
  assign alien_speed = r_speed;
  assign play_en     = r_playEn;
  assign wave_reset  = r_waveReset;
  assign respawn     = r_respawn;
  assign show_start  = r_showStart;
  assign show_banner = r_showBanner;
  assign game_over   = r_gameOver;

endmodule
